// File: rtl/display_share_arbiter.sv
// Round-robin owner of the shared 8-digit seven-segment display.
// The owner is held for a minimum dwell time, and the display is blanked for a gap on every handover.
// All outputs are registered.
module display_share_arbiter #(
   parameter int unsigned NUM_SRC    = 4,
   parameter logic [23:0] DWELL      = 24'd5000,
   parameter logic [7:0]  GAP_CYCLES = 8'd4,
   parameter int unsigned SW         = $clog2(NUM_SRC)
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic [NUM_SRC-1:0]      REQ,
   input  logic [32*NUM_SRC-1:0]   HEX_BUS,
   input  logic [8*NUM_SRC-1:0]    EN_BUS,
   output logic [NUM_SRC-1:0]      GNT,
   output logic [31:0]             HEX_OUT,
   output logic [7:0]              DISP_EN_OUT,
   output logic [SW-1:0]           OWNER,
   output logic                    BUSY
);

   typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

   state_e               state, state_n;
   logic [SW-1:0]        last, last_n, owner_n, pick;
   logic [23:0]          dwell_cnt, dwell_n;
   logic [7:0]           gap_cnt, gap_n;
   logic [NUM_SRC-1:0]   gnt_n;
   logic [31:0]          hex_n;
   logic [7:0]           en_n;
   logic [31:0]          hex_arr [NUM_SRC];
   logic [7:0]           en_arr  [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign hex_arr[i] = HEX_BUS[32*i +: 32];
      assign en_arr[i]  = EN_BUS[8*i +: 8];
   end

   // First requester after 'from', wrapping; 'from' itself is tried last.
   function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                             input logic [SW-1:0] from);
      logic [SW-1:0] win;
      logic          found;
      int unsigned   idx;
      win   = from;
      found = 1'b0;
      for (int unsigned off = 1; off <= NUM_SRC; off++) begin
         idx = (32'(from) + off) % NUM_SRC;
         if (!found && req[SW'(idx)]) begin
            found = 1'b1;
            win   = SW'(idx);
         end
      end
      return win;
   endfunction

   assign pick = rr_pick(REQ, last);

   // Next-state and next-output logic for the arbitration FSM.
   always_comb begin
      state_n = state;
      last_n  = last;
      owner_n = OWNER;
      dwell_n = dwell_cnt;
      gap_n   = gap_cnt;
      gnt_n   = GNT;
      hex_n   = HEX_OUT;
      en_n    = DISP_EN_OUT;
      case (state)
         StIdle: begin
            gnt_n = '0;
            en_n  = '0;
            if (|REQ) begin
               state_n = StHold;
               gnt_n   = NUM_SRC'(1) << pick;
               owner_n = pick;
               last_n  = pick;
               dwell_n = '0;
            end
         end
         StHold: begin
            hex_n = hex_arr[OWNER];
            en_n  = en_arr[OWNER];
            if (dwell_cnt != DWELL - 24'd1) dwell_n = dwell_cnt + 24'd1;
            // A dropped request always wins over a pending competitor.
            if (!REQ[OWNER] ||
                ((dwell_cnt == DWELL - 24'd1) && ((REQ & ~GNT) != '0))) begin
               state_n = StGap;
               gnt_n   = '0;
               en_n    = '0;
               gap_n   = '0;
            end
         end
         StGap: begin
            gnt_n = '0;
            en_n  = '0;
            if (gap_cnt == GAP_CYCLES - 8'd1) begin
               gap_n = '0;
               if (|REQ) begin
                  state_n = StHold;
                  gnt_n   = NUM_SRC'(1) << pick;
                  owner_n = pick;
                  last_n  = pick;
                  dwell_n = '0;
               end else begin
                  state_n = StIdle;
               end
            end else begin
               gap_n = gap_cnt + 8'd1;
            end
         end
         default: state_n = StIdle;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state       <= StIdle;
         last        <= SW'(NUM_SRC - 1);
         OWNER       <= '0;
         dwell_cnt   <= '0;
         gap_cnt     <= '0;
         GNT         <= '0;
         HEX_OUT     <= '0;
         DISP_EN_OUT <= '0;
         BUSY        <= 1'b0;
      end else begin
         state       <= state_n;
         last        <= last_n;
         OWNER       <= owner_n;
         dwell_cnt   <= dwell_n;
         gap_cnt     <= gap_n;
         GNT         <= gnt_n;
         HEX_OUT     <= hex_n;
         DISP_EN_OUT <= en_n;
         BUSY        <= (state_n != StIdle);
      end
   end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Scoreboard bench for display_share_arbiter: a cycle-level reference model queues expected
// outputs at each rising edge, and a monitor compares them on the falling edge.
module tb_display_share_arbiter;

   localparam int NSRC = 4;
   localparam int DW   = 10;
   localparam int GAPN = 2;

   bit           clk;
   logic         rst_n;
   logic [3:0]   req;
   logic [127:0] hex_bus;
   logic [31:0]  en_bus;
   logic [3:0]   gnt;
   logic [31:0]  hex_out;
   logic [7:0]   disp_en;
   logic [1:0]   owner;
   logic         busy;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  gnt;
      logic [31:0] hex;
      logic [7:0]  en;
      logic [1:0]  owner;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];

   display_share_arbiter #(
      .NUM_SRC   (NSRC),
      .DWELL     (24'd10),
      .GAP_CYCLES(8'd2),
      .SW        (2)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .REQ        (req),
      .HEX_BUS    (hex_bus),
      .EN_BUS     (en_bus),
      .GNT        (gnt),
      .HEX_OUT    (hex_out),
      .DISP_EN_OUT(disp_en),
      .OWNER      (owner),
      .BUSY       (busy)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 idle, 1 owner displayed, 2 blank gap.
   int          m_mode, m_owner, m_last, m_held, m_gap;
   logic [3:0]  m_gnt;
   logic [31:0] m_hex;
   logic [7:0]  m_en;

   function automatic int winner(input logic [3:0] r, input int from);
      for (int k = 1; k <= NSRC; k++) begin
         if (r[(from + k) % NSRC]) return (from + k) % NSRC;
      end
      return 0;
   endfunction

   task automatic hand_to(input logic [3:0] r);
      int w;
      w       = winner(r, m_last);
      m_mode  = 1;
      m_owner = w;
      m_last  = w;
      m_held  = 0;
      m_gnt   = 4'b1 << w;
   endtask

   task automatic model_step();
      bit   leave;
      exp_t e;
      if (!rst_n) begin
         m_mode = 0; m_owner = 0; m_last = NSRC - 1; m_held = 0; m_gap = 0;
         m_gnt = 0; m_hex = 0; m_en = 0;
      end else if (m_mode == 0) begin
         m_gnt = 0;
         m_en  = 0;
         if (req != 0) hand_to(req);
      end else if (m_mode == 1) begin
         m_hex = hex_bus[32*m_owner +: 32];
         leave = !req[m_owner] ||
                 (m_held >= DW - 1 && (req & ~(4'b1 << m_owner)) != 0);
         if (leave) begin
            m_mode = 2; m_gap = 0; m_gnt = 0; m_en = 0;
         end else begin
            m_en   = en_bus[8*m_owner +: 8];
            m_held = m_held + 1;
         end
      end else begin
         if (m_gap == GAPN - 1) begin
            if (req != 0) hand_to(req);
            else m_mode = 0;
         end else begin
            m_gap = m_gap + 1;
         end
      end
      e.gnt   = m_gnt;
      e.hex   = m_hex;
      e.en    = m_en;
      e.owner = 2'(m_owner);
      e.busy  = (m_mode != 0);
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Monitor: compare one expected entry per cycle, away from the active edge.
   initial forever begin
      exp_t e;
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
      end else begin
         e = exp_q.pop_front();
         checks += 4;
         if (gnt !== e.gnt) begin
            errors++;
            $display("FAIL gnt at %0t: got %b required %b", $time, gnt, e.gnt);
         end
         if (hex_out !== e.hex) begin
            errors++;
            $display("FAIL hex_out at %0t: got %h required %h", $time, hex_out, e.hex);
         end
         if (disp_en !== e.en) begin
            errors++;
            $display("FAIL disp_en at %0t: got %h required %h", $time, disp_en, e.en);
         end
         if (owner !== e.owner) begin
            errors++;
            $display("FAIL owner at %0t: got %0d required %0d", $time, owner, e.owner);
         end
         if (busy !== e.busy) begin
            errors++;
            $display("FAIL busy at %0t: got %b required %b", $time, busy, e.busy);
         end
      end
   end

   task automatic rand_data();
      hex_bus = {$urandom, $urandom, $urandom, $urandom};
      en_bus  = $urandom;
   endtask

   // Hold the given request for n cycles; inputs change 2 time units after the edge.
   task automatic run(input int n, input logic [3:0] r, input bit rnd);
      for (int i = 0; i < n; i++) begin
         req = r;
         if (rnd) rand_data();
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'hF;
      rand_data();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      run(6, 4'hF, 1'b1);
      // Lone requester 2 with a fixed word: held far beyond the dwell time.
      rand_data();
      hex_bus[95:64] = 32'h1234ABCD;
      en_bus[23:16]  = 8'hFF;
      run(110, 4'b0100, 1'b0);
      // Three constant requesters rotate with dwell expiry.
      run(60, 4'b1011, 1'b1);
      // Owner drops early while another source waits.
      run(40, 4'b0110, 1'b1);
      run(3, 4'b0100, 1'b1);
      run(20, 4'b0110, 1'b1);
      // Reset pulse in the middle of a hold.
      rst_n = 1'b0;
      run(1, 4'b1111, 1'b1);
      rst_n = 1'b1;
      run(30, 4'b1111, 1'b1);
      // Everyone gives up: gap, then idle with the last word kept.
      run(11, 4'b0001, 1'b1);
      run(20, 4'b0000, 1'b1);
      // Randomised traffic with occasional resets.
      req = 4'h0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 11) == 0) req = 4'($urandom);
         rst_n = ($urandom_range(0, 299) != 0);
         rand_data();
         @(posedge clk);
         #2;
      end
      rst_n = 1'b1;
      run(5, 4'h0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
